// File: rtl/sim_run_ctrl.sv
// Run controller for CPU simulation benches: holds the core in reset, counts run cycles, records halts.
// Optional per-channel hang watchdog is enabled by defining SIM_RUN_CTRL_WDOG_EN.
module sim_run_ctrl #(
  parameter int NUM_CH      = 1,
  parameter int CNT_W       = 16,
  parameter int RST_CYCLES  = 4,
`ifdef SIM_RUN_CTRL_WDOG_EN
  parameter int MAX_CYCLES  = 20,
  parameter int WDOG_CYCLES = 8
`else
  parameter int MAX_CYCLES  = 20
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       halt_in,
`ifdef SIM_RUN_CTRL_WDOG_EN
  input  logic [NUM_CH-1:0]       retire,
  output logic [NUM_CH-1:0]       hang,
`endif
  output logic                    cpu_reset,
  output logic                    running,
  output logic                    done,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [NUM_CH-1:0]       halt_seen,
  output logic [NUM_CH*CNT_W-1:0] halt_cyc
);

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_TOUT = 2'd3;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  rst_cnt;
  logic [NUM_CH-1:0] new_halt;
  logic              all_h;
  logic              force_tout;
  logic              restart;

  // A channel counts as halted this cycle if it was already captured or is halting now.
  assign new_halt = halt_in & ~halt_seen;
  assign all_h    = &(halt_seen | halt_in);
  assign restart  = ((state == S_DONE) || (state == S_TOUT)) && start;

  assign cpu_reset = (state == S_RST);
  assign running   = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign timeout   = (state == S_TOUT);

`ifdef SIM_RUN_CTRL_WDOG_EN
  localparam int IDLE_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [IDLE_W-1:0] WDOG_LAST = IDLE_W'(WDOG_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  logic [NUM_CH-1:0][IDLE_W-1:0] idle_cnt;

  assign force_tout = |hang;

  // Idle counters stop once their channel has hung; hang stays set until reset or restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      hang     <= '0;
    end else if (restart) begin
      idle_cnt <= '0;
      hang     <= '0;
    end else if (state == S_RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (retire[i] || halt_seen[i]) begin
          idle_cnt[i] <= '0;
        end else if (!hang[i]) begin
          idle_cnt[i] <= idle_cnt[i] + IDLE_ONE;
          if (idle_cnt[i] == WDOG_LAST) hang[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign force_tout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RST;
      rst_cnt     <= '0;
      cycle_count <= '0;
      halt_seen   <= '0;
      halt_cyc    <= '0;
    end else begin
      case (state)
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            state   <= S_RUN;
            rst_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (new_halt[i]) halt_cyc[i*CNT_W +: CNT_W] <= cycle_count;
          end
          halt_seen   <= halt_seen | halt_in;
          cycle_count <= cycle_count + CNT_ONE;
          // A halt completing on the last allowed cycle still counts as DONE.
          if (all_h) begin
            state <= S_DONE;
          end else if (force_tout || (cycle_count == RUN_LAST)) begin
            state <= S_TOUT;
          end
        end
        default: begin
          if (start) begin
            state       <= S_RST;
            rst_cnt     <= '0;
            cycle_count <= '0;
            halt_seen   <= '0;
            halt_cyc    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl with two halt channels and default cycle limits.
module tb_sim_run_ctrl;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic [NUM_CH-1:0]       halt_in = '0;
  logic                    cpu_reset, running, done, timeout;
  logic [CNT_W-1:0]        cycle_count;
  logic [NUM_CH-1:0]       halt_seen;
  logic [NUM_CH*CNT_W-1:0] halt_cyc;
`ifdef SIM_RUN_CTRL_WDOG_EN
  logic [NUM_CH-1:0]       retire = '1;
  logic [NUM_CH-1:0]       hang;
`endif

  int checks = 0;
  int errors = 0;

  sim_run_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .halt_in(halt_in),
`ifdef SIM_RUN_CTRL_WDOG_EN
    .retire(retire),
    .hang(hang),
`endif
    .cpu_reset(cpu_reset),
    .running(running),
    .done(done),
    .timeout(timeout),
    .cycle_count(cycle_count),
    .halt_seen(halt_seen),
    .halt_cyc(halt_cyc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Four cycles of cpu_reset, then RUN with a zero count.
  task automatic rst_seq(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_cpu_reset"}, cpu_reset, 1);
    end
    step();
    chk({tag, "_running"}, running, 1);
    chk({tag, "_cpu_reset_low"}, cpu_reset, 0);
    chk({tag, "_count0"}, cycle_count, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_halt_seen", halt_seen, 0);
    chk("rst_halt_cyc", halt_cyc, 0);
    step();
    step();
    reset = 1'b0;
    rst_seq("boot");

    // No halts: run to the 20-cycle limit.
    for (int k = 1; k < 20; k++) begin
      step();
      if (k == 10) chk("t1_count10", cycle_count, 10);
    end
    chk("t1_running19", running, 1);
    step();
    chk("t1_timeout", timeout, 1);
    chk("t1_running_low", running, 0);
    chk("t1_done_low", done, 0);
    chk("t1_count", cycle_count, 20);
    chk("t1_halt_seen", halt_seen, 0);
    step();
    chk("t1_frozen", cycle_count, 20);

    pulse_start();
    chk("t1_restart_cpu_reset", cpu_reset, 1);
    chk("t1_restart_timeout", timeout, 0);
    chk("t1_restart_count", cycle_count, 0);
    rst_seq("run2");

    // Both channels halt at cycles 5 and 9; start during RUN is ignored.
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_start_ignored", running, 1);
    chk("t2_count3", cycle_count, 3);
    step();
    step();
    halt_in = 2'b01;
    step();
    chk("t2_seen0", halt_seen, 2'b01);
    chk("t2_cyc0", halt_cyc[CNT_W-1:0], 5);
    chk("t2_still_running", running, 1);
    step();
    step();
    step();
    chk("t2_count9", cycle_count, 9);
    halt_in = 2'b11;
    step();
    chk("t2_done", done, 1);
    chk("t2_running_low", running, 0);
    chk("t2_count", cycle_count, 10);
    chk("t2_halt_seen", halt_seen, 2'b11);
    chk("t2_halt_cyc", halt_cyc, 32'h0009_0005);
    halt_in = 2'b00;
    step();
    step();
    chk("t2_frozen_count", cycle_count, 10);
    chk("t2_frozen_done", done, 1);
    chk("t2_frozen_seen", halt_seen, 2'b11);

    pulse_start();
    chk("t2_restart_cpu_reset", cpu_reset, 1);
    chk("t2_restart_seen", halt_seen, 0);
    chk("t2_restart_cyc", halt_cyc, 0);
    chk("t2_restart_count", cycle_count, 0);
    rst_seq("run3");

    // One-cycle pulse on ch0 at 3; ch1 halts on the last allowed cycle -> DONE wins.
    step();
    step();
    step();
    halt_in = 2'b01;
    step();
    halt_in = 2'b00;
    chk("t3_seen0", halt_seen, 2'b01);
    for (int k = 4; k < 19; k++) step();
    chk("t3_count19", cycle_count, 19);
    chk("t3_running19", running, 1);
    chk("t3_sticky", halt_seen, 2'b01);
    halt_in = 2'b10;
    step();
    halt_in = 2'b00;
    chk("t3_done", done, 1);
    chk("t3_no_timeout", timeout, 0);
    chk("t3_count", cycle_count, 20);
    chk("t3_halt_cyc", halt_cyc, 32'h0013_0003);

    pulse_start();
    rst_seq("run4");

    // Asynchronous reset in the middle of a run.
    for (int k = 0; k < 7; k++) step();
    chk("t4_count7", cycle_count, 7);
    halt_in = 2'b01;
    step();
    halt_in = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    chk("t4_cpu_reset", cpu_reset, 1);
    chk("t4_running", running, 0);
    chk("t4_count", cycle_count, 0);
    chk("t4_halt_seen", halt_seen, 0);
    chk("t4_halt_cyc", halt_cyc, 0);
    step();
    reset = 1'b0;
    rst_seq("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
